spi_responder: RTL

SPI mode-0 responder (slave) for the jtagspi design: the target-side counterpart of `spi_interface`, for on-chip loopback benches and for designs where the FPGA itself is the SPI target. It oversamples `sclk`, `cs_n` and `mosi` in the system clock domain, deserialises received bytes and serialises transmit bytes MSB first. A byte-wide handshake connects it to the user logic.

---
 rtl/spi_pkg.sv | 10 +
 rtl/spi_sync.sv | 22 ++
 rtl/spi_responder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and state type for the SPI responder
package spi_pkg;
  localparam int SPI_BYTE_W = 8;

  typedef enum logic [1:0] {
    WAIT_HI,
    IDLE,
    SHIFT
  } spi_resp_state_t;
endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - single-bit multi-stage synchroniser with selectable reset value
module spi_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/spi_responder.sv
// rtl/spi_responder.sv - SPI mode-0 target: oversampled pins, byte handshake to user logic
module spi_responder
  import spi_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_MISO   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  output logic                  tx_load,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic [15:0]           byte_cnt,
  output logic                  frame_end,
  output logic                  partial
);
  // cs_n synchroniser resets high, so its output is only trusted once this many cycles have passed
  localparam logic [7:0] SETTLE = 8'(SYNC_STAGES);

  logic sclk_s, cs_s, mosi_s;
  logic sclk_prev_q, cs_prev_q;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d_i(sclk), .q_o(sclk_s));
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst(rst), .d_i(cs_n), .q_o(cs_s));
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d_i(mosi), .q_o(mosi_s));

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  spi_resp_state_t       state_q, state_d;
  logic [SPI_BYTE_W-1:0] tx_sr_q, tx_sr_d;
  logic [SPI_BYTE_W-2:0] rx_sr_q, rx_sr_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic                  reload_q, reload_d;
  logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tx_load_q, tx_load_d;
  logic [15:0]           byte_cnt_q, byte_cnt_d;
  logic                  frame_end_q, frame_end_d;
  logic                  partial_q, partial_d;
  logic [7:0]            settle_q, settle_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= WAIT_HI;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      bit_cnt_q   <= '0;
      reload_q    <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_load_q   <= 1'b0;
      byte_cnt_q  <= '0;
      frame_end_q <= 1'b0;
      partial_q   <= 1'b0;
      settle_q    <= '0;
    end else begin
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      state_q     <= state_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      reload_q    <= reload_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_load_q   <= tx_load_d;
      byte_cnt_q  <= byte_cnt_d;
      frame_end_q <= frame_end_d;
      partial_q   <= partial_d;
      settle_q    <= settle_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    bit_cnt_d   = bit_cnt_q;
    reload_d    = reload_q;
    rx_data_d   = rx_data_q;
    byte_cnt_d  = byte_cnt_q;
    settle_d    = settle_q;
    rx_valid_d  = 1'b0;
    tx_load_d   = 1'b0;
    frame_end_d = 1'b0;
    partial_d   = 1'b0;
    miso        = IDLE_MISO;
    miso_oe     = 1'b0;

    case (state_q)
      WAIT_HI: begin
        bit_cnt_d = '0;
        if (settle_q != SETTLE) begin
          settle_d = settle_q + 8'd1;
        end else if (cs_s) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        bit_cnt_d = '0;
        reload_d  = 1'b0;
        if (cs_fall) begin
          tx_sr_d    = tx_data;
          tx_load_d  = 1'b1;
          byte_cnt_d = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        miso    = tx_sr_q[SPI_BYTE_W-1];
        miso_oe = 1'b1;
        // deselect takes priority over any sclk edge seen in the same cycle
        if (cs_rise) begin
          state_d     = IDLE;
          frame_end_d = 1'b1;
          partial_d   = (bit_cnt_q != 3'd0);
        end else if (sclk_rise) begin
          rx_sr_d = {rx_sr_q[SPI_BYTE_W-3:0], mosi_s};
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = {rx_sr_q, mosi_s};
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            reload_d   = 1'b1;
            if (byte_cnt_q != 16'hFFFF) begin
              byte_cnt_d = byte_cnt_q + 16'd1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else if (sclk_fall) begin
          if (reload_q) begin
            tx_sr_d   = tx_data;
            tx_load_d = 1'b1;
            reload_d  = 1'b0;
          end else begin
            tx_sr_d = {tx_sr_q[SPI_BYTE_W-2:0], 1'b0};
          end
        end
      end
      default: state_d = WAIT_HI;
    endcase
  end

  assign tx_load   = tx_load_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign byte_cnt  = byte_cnt_q;
  assign frame_end = frame_end_q;
  assign partial   = partial_q;
endmodule
